// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types, constants and helpers for the keypad decoder.
//   kd_state_t      - decoder FSM states
//   KEYS_ALL_UP     - active-low key vector with no key pressed
//   onehot_n_count  - number of zero bits in a key vector, saturating at 2
//   lowest_zero_idx - index of the lowest zero bit (4*row+col)
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    HELD
  } kd_state_t;

  localparam logic [15:0] KEYS_ALL_UP = 16'hFFFF;

  function automatic logic [1:0] onehot_n_count(input logic [15:0] v);
    logic [1:0] n;
    n = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (!v[i] && n != 2'd2) n = n + 2'd1;
    end
    return n;
  endfunction

  function automatic logic [3:0] lowest_zero_idx(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    // Scan downwards so the last hit is the lowest zero.
    for (int unsigned i = 16; i > 0; i--) begin
      if (!v[i-1]) idx = 4'(i - 1);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_event_fifo.sv
// keypad_event_fifo: small registered FIFO for decoded key events.
// Parameters: WIDTH (entry width), DEPTH (entries, power of 2, >= 2).
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   push        - enqueue push_code this cycle
//   push_code   - event data
//   pop_ready   - consumer accepts head when head_valid is high
//   head_code   - FIFO head (0 while empty)
//   head_valid  - FIFO not empty
//   overflow    - sticky: an event was dropped because the FIFO was full
module keypad_event_fifo
  import keypad_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_code,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] head_code,
  output logic             head_valid,
  output logic             overflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;

  // Extra MSB on the pointers tells full (MSBs differ) from empty (equal).
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = !empty && pop_ready;
  // A pop in the same cycle frees the slot, so a push while full still lands.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      if (push && !do_push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr[AW-1:0]] <= push_code;
  end

  assign head_valid = !empty;
  assign head_code  = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/keypad_key_decoder.sv
// keypad_key_decoder: synchronises and debounces the active-low 4x4 key
// vector, rejects multi-key presses, encodes single presses and queues them.
// Optional feature macro: KEY_REPEAT_EN (auto-repeat while a key is held).
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   key_n      - raw key vector, bit 4*row+col, 0 = pressed (asynchronous)
//   key_code   - FIFO head key index
//   key_valid  - FIFO not empty
//   key_ready  - consumer accepts head when key_valid is high
//   key_held   - a single debounced key is currently held
//   multi_key  - 1-cycle pulse on a debounced multi-key press
//   overflow   - sticky event-drop flag
module keypad_key_decoder
  import keypad_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV   = 50000,
  parameter int unsigned DEB_SAMPLES  = 10,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned REPEAT_DELAY = 500,
  parameter int unsigned REPEAT_RATE  = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] key_n,
  output logic [3:0]  key_code,
  output logic        key_valid,
  input  logic        key_ready,
  output logic        key_held,
  output logic        multi_key,
  output logic        overflow
);

  localparam int unsigned DW = $clog2(SAMPLE_DIV);

  logic [15:0]   sync1, sync2, sample;
  logic [DW-1:0] div_cnt;
  logic          tick;

  kd_state_t   state, state_n;
  logic [15:0] cand, cand_n;
  logic [7:0]  cnt, cnt_n;
  logic [3:0]  code_q, code_n;
  logic        held_q, held_n;
  logic        multi_q, multi_n;
  logic        push;
  logic [3:0]  push_code;

`ifdef KEY_REPEAT_EN
  logic [15:0] rep_cnt, rep_cnt_n;
  logic        rep_first, rep_first_n;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  assign sample = sync2;
  assign tick   = (div_cnt == DW'(SAMPLE_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst)       div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cand    <= '1;
      cnt     <= '0;
      code_q  <= '0;
      held_q  <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      state   <= state_n;
      cand    <= cand_n;
      cnt     <= cnt_n;
      code_q  <= code_n;
      held_q  <= held_n;
      multi_q <= multi_n;
    end
  end

`ifdef KEY_REPEAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else begin
      rep_cnt   <= rep_cnt_n;
      rep_first <= rep_first_n;
    end
  end
`endif

  // In HELD, cnt is reused as the consecutive all-up (release) counter.
  always_comb begin
    state_n   = state;
    cand_n    = cand;
    cnt_n     = cnt;
    code_n    = code_q;
    held_n    = held_q;
    multi_n   = 1'b0;
    push      = 1'b0;
    push_code = code_q;
`ifdef KEY_REPEAT_EN
    rep_cnt_n   = rep_cnt;
    rep_first_n = rep_first;
`endif
    if (tick) begin
      case (state)
        IDLE: begin
          if (sample != KEYS_ALL_UP) begin
            cand_n  = sample;
            cnt_n   = 8'd1;
            state_n = DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (sample == cand) begin
            cnt_n = cnt + 8'd1;
            if (cnt + 8'd1 == 8'(DEB_SAMPLES)) begin
              state_n = HELD;
              cnt_n   = '0;
              if (onehot_n_count(cand) == 2'd1) begin
                push      = 1'b1;
                push_code = lowest_zero_idx(cand);
                code_n    = lowest_zero_idx(cand);
                held_n    = 1'b1;
              end else begin
                multi_n = 1'b1;
                held_n  = 1'b0;
              end
`ifdef KEY_REPEAT_EN
              rep_cnt_n   = '0;
              rep_first_n = 1'b1;
`endif
            end
          end else if (sample == KEYS_ALL_UP) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            cand_n = sample;
            cnt_n  = 8'd1;
          end
        end
        HELD: begin
          if (sample == KEYS_ALL_UP) begin
            if (cnt + 8'd1 == 8'(DEB_SAMPLES)) begin
              state_n = IDLE;
              cnt_n   = '0;
              held_n  = 1'b0;
`ifdef KEY_REPEAT_EN
              rep_cnt_n   = '0;
              rep_first_n = 1'b1;
`endif
            end else begin
              cnt_n = cnt + 8'd1;
            end
          end else begin
            cnt_n = '0;
`ifdef KEY_REPEAT_EN
            // Repeat only advances on ticks where a key is still down.
            if (held_q) begin
              if (rep_cnt + 16'd1 == (rep_first ? 16'(REPEAT_DELAY) : 16'(REPEAT_RATE))) begin
                push        = 1'b1;
                push_code   = code_q;
                rep_cnt_n   = '0;
                rep_first_n = 1'b0;
              end else begin
                rep_cnt_n = rep_cnt + 16'd1;
              end
            end
`endif
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign key_held  = held_q;
  assign multi_key = multi_q;

  keypad_event_fifo #(
    .WIDTH (4),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_code  (push_code),
    .pop_ready  (key_ready),
    .head_code  (key_code),
    .head_valid (key_valid),
    .overflow   (overflow)
  );

endmodule

// File: tb/tb_keypad_key_decoder.sv
// Testbench for keypad_key_decoder. Stimulus is applied in tick-sized slots
// (SAMPLE_DIV clocks) aligned to reset release; a run-length reference model
// predicts events into a queue that a separate monitor drains and compares.
module tb_keypad_key_decoder;

  localparam int unsigned SD = 4;
  localparam int unsigned DS = 3;
  localparam int unsigned FD = 4;
  localparam int unsigned RD = 5;
  localparam int unsigned RR = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] key_n = '1;
  logic        key_ready = 1'b0;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic        multi_key;
  logic        overflow;

  always #5 clk = ~clk;

  keypad_key_decoder #(
    .SAMPLE_DIV   (SD),
    .DEB_SAMPLES  (DS),
    .FIFO_DEPTH   (FD),
    .REPEAT_DELAY (RD),
    .REPEAT_RATE  (RR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_n     (key_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_held  (key_held),
    .multi_key (multi_key),
    .overflow  (overflow)
  );

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];
  int pops = 0;
  int multi_seen = 0;

  // Reference model state (run lengths of identical samples)
  logic [15:0] m_last;
  int m_run, m_rel, m_rep, m_code, m_multi_total;
  bit m_pressed, m_held, m_first, m_multi, m_ovf;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compare every accepted FIFO head against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (multi_key) multi_seen++;
      if (key_valid && key_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_event: got code %0d, expected no event", key_code);
        end else begin
          check("event_code", int'(key_code), exp_q.pop_front());
        end
        pops++;
      end
    end
  end

  task automatic model_reset();
    m_last = '1; m_run = 0; m_rel = 0; m_rep = 0; m_code = 0;
    m_pressed = 0; m_held = 0; m_first = 1; m_multi = 0; m_ovf = 0;
    exp_q.delete();
  endtask

  task automatic model_push(input int c);
    if (exp_q.size() >= FD) m_ovf = 1;
    else exp_q.push_back(c);
  endtask

  task automatic model_tick(input logic [15:0] s);
    m_multi = 0;
    if (!m_pressed) begin
      if (s == 16'hFFFF)    m_run = 0;
      else if (s == m_last) m_run++;
      else                  m_run = 1;
      if (m_run == DS) begin
        m_pressed = 1; m_rel = 0; m_run = 0;
        if ($countones(~s) == 1) begin
          m_held = 1; m_code = $clog2(~s); m_rep = 0; m_first = 1;
          model_push(m_code);
        end else begin
          m_held = 0; m_multi = 1; m_multi_total++;
        end
      end
    end else begin
      if (s == 16'hFFFF) begin
        m_rel++;
        if (m_rel == DS) begin m_pressed = 0; m_held = 0; end
      end else begin
        m_rel = 0;
`ifdef KEY_REPEAT_EN
        if (m_held) begin
          m_rep++;
          if (m_rep == (m_first ? RD : RR)) begin
            model_push(m_code); m_rep = 0; m_first = 0;
          end
        end
`endif
      end
    end
    m_last = s;
  endtask

  // One sample period; starts and ends at the negedge after a tick edge.
  task automatic slot(input logic [15:0] v, input bit rdy, input bit pulse);
    key_n = v;
    @(posedge clk); #2 key_ready = rdy;
    @(posedge clk);
    @(posedge clk); if (pulse) #2 key_ready = 1'b1;
    @(posedge clk); #1;
    if (pulse) key_ready = rdy;
    model_tick(v);
    check("key_held", int'(key_held), int'(m_held));
    check("multi_key", int'(multi_key), int'(m_multi));
    check("overflow", int'(overflow), int'(m_ovf));
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_valid", int'(key_valid), 0);
    check("rst_code", int'(key_code), 0);
    check("rst_held", int'(key_held), 0);
    check("rst_multi", int'(multi_key), 0);
    check("rst_ovf", int'(overflow), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic press(input int code, input bit rdy, input bit pulse_accept);
    logic [15:0] v;
    v = ~(16'h0001 << code);
    for (int i = 0; i < 4; i++) slot(v, rdy, pulse_accept && (i == 2));
    for (int i = 0; i < 4; i++) slot('1, rdy, 1'b0);
  endtask

  initial begin
    int p0, mm0, exp_rep;
    logic [15:0] v;
    int hold;
    int b0, b1;
    bit r;
    m_multi_total = 0;
    @(negedge clk);
    do_reset();

    // 1: single key 5 held 20 ticks
    p0 = pops;
    for (int i = 0; i < 20; i++) slot(~16'h0020, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++)  slot('1, 1'b1, 1'b0);
    check("t1_events", pops - p0, 1);

    // 2: bouncing key 0, then settled
    p0 = pops;
    for (int i = 0; i < 10; i++) slot((i % 2 == 0) ? ~16'h0001 : 16'hFFFF, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++)  slot(~16'h0001, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++)  slot('1, 1'b1, 1'b0);
    check("t2_events", pops - p0, 1);

    // 3: ghost press keys 0 and 7
    p0 = pops; mm0 = multi_seen;
    for (int i = 0; i < 6; i++) slot(~16'h0081, 1'b1, 1'b0);
    check("t3_held", int'(key_held), 0);
    for (int i = 0; i < 4; i++) slot('1, 1'b1, 1'b0);
    check("t3_events", pops - p0, 0);
    check("t3_multi", multi_seen - mm0, 1);

    // 4: overflow with consumer stalled, then drain in order
    p0 = pops;
    press(1, 1'b0, 1'b0); press(2, 1'b0, 1'b0); press(3, 1'b0, 1'b0);
    press(4, 1'b0, 1'b0); press(6, 1'b0, 1'b0);
    check("t4_ovf", int'(overflow), 1);
    check("t4_valid_full", int'(key_valid), 1);
    for (int i = 0; i < 3; i++) slot('1, 1'b1, 1'b0);
    check("t4_events", pops - p0, 4);
    check("t4_valid_drained", int'(key_valid), 0);

    // 5: push into a full FIFO in the same cycle as a pop
    do_reset();
    p0 = pops;
    press(1, 1'b0, 1'b0); press(2, 1'b0, 1'b0); press(3, 1'b0, 1'b0); press(4, 1'b0, 1'b0);
    press(6, 1'b0, 1'b1);
    check("t5_ovf", int'(overflow), 0);
    for (int i = 0; i < 3; i++) slot('1, 1'b1, 1'b0);
    check("t5_events", pops - p0, 5);

    // 6: key 9 held 12 ticks past acceptance
    p0 = pops;
`ifdef KEY_REPEAT_EN
    exp_rep = 5;
`else
    exp_rep = 1;
`endif
    for (int i = 0; i < 15; i++) slot(~16'h0200, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++)  slot('1, 1'b1, 1'b0);
    check("t6_events", pops - p0, exp_rep);

    // 7: reset during debounce of key 3, key still held afterwards
    for (int i = 0; i < 2; i++) slot(~16'h0008, 1'b1, 1'b0);
    do_reset();
    p0 = pops;
    for (int i = 0; i < 2; i++) slot(~16'h0008, 1'b1, 1'b0);
    check("t7_no_early_event", pops - p0, 0);
    for (int i = 0; i < 2; i++) slot(~16'h0008, 1'b1, 1'b0);
    check("t7_event_after_debounce", pops - p0, 1);
    for (int i = 0; i < 4; i++) slot('1, 1'b1, 1'b0);

    // Random phase: bouncy single/multi presses with an intermittent consumer
    do_reset();
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: v = '1;
        5, 6, 7, 8:    v = ~(16'h0001 << $urandom_range(0, 15));
        default: begin
          b0 = $urandom_range(0, 15);
          do b1 = $urandom_range(0, 15); while (b1 == b0);
          v = ~((16'h0001 << b0) | (16'h0001 << b1));
        end
      endcase
      hold = $urandom_range(1, 6);
      for (int i = 0; i < hold; i++) begin
        r = ($urandom_range(0, 9) < 7);
        slot(v, r, 1'b0);
      end
    end
    for (int i = 0; i < 8; i++) slot('1, 1'b1, 1'b0);

    check("final_queue_empty", exp_q.size(), 0);
    check("multi_total", multi_seen, m_multi_total);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
